// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates funct3 and alignment, drives one memory access per
// request, and returns extended load data with a one-cycle response pulse.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_addr_unit,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [1:0] UNIT_NOP = 2'b11;

  logic [1:0]            state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic                  illegal;
  logic                  misaligned;
  logic [WORD_WIDTH-1:0] store_data;
  logic [WORD_WIDTH-1:0] load_ext;

  assign req_ready = (state == IDLE);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    store_data = '0;

    if (req_we) begin
      illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
    end

    // funct3[1:0] encodes the access size for every legal load and store.
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    case (req_funct3[1:0])
      2'b00:   store_data[7:0]  = req_wdata[7:0];
      2'b01:   store_data[15:0] = req_wdata[15:0];
      default: store_data       = req_wdata;
    endcase
  end

  always_comb begin
    load_ext = mem_data_out;
    case (funct3_q)
      3'b000:  load_ext = {{(WORD_WIDTH-8){mem_data_out[7]}}, mem_data_out[7:0]};
      3'b100:  load_ext = {{(WORD_WIDTH-8){1'b0}}, mem_data_out[7:0]};
      3'b001:  load_ext = {{(WORD_WIDTH-16){mem_data_out[15]}}, mem_data_out[15:0]};
      3'b101:  load_ext = {{(WORD_WIDTH-16){1'b0}}, mem_data_out[15:0]};
      default: load_ext = mem_data_out;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr_unit <= UNIT_NOP;
      mem_address   <= '0;
      mem_data_in   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            if (illegal || misaligned) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state         <= ISSUE;
              mem_read      <= !req_we;
              mem_write     <= req_we;
              mem_addr_unit <= req_funct3[1:0];
              mem_address   <= req_addr;
              mem_data_in   <= store_data;
            end
          end
        end
        ISSUE: begin
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          mem_addr_unit <= UNIT_NOP;
          if (we_q) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_ext;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
